// File: rtl/clk_divider_bank.sv
// rtl/clk_divider_bank.sv - bank of N_CH programmable square-wave dividers with per-edge ticks
// Optional phase-align restart input sync_req is built only when CLKDIV_SYNC_EN is defined.
module clk_divider_bank #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 8,
    parameter logic [N_CH*CNT_W-1:0] DEF_HP = {8'd50, 8'd5, 8'd0}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           en,
    input  logic                      div_wr,
    input  logic [$clog2(N_CH):0]     div_sel,
    input  logic [CNT_W-1:0]          div_val,
`ifdef CLKDIV_SYNC_EN
    input  logic                      sync_req,
`endif
    output logic [N_CH-1:0]           clk_out,
    output logic [N_CH-1:0]           tick
);

    localparam int SEL_W = $clog2(N_CH) + 1;

    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [CNT_W-1:0] hp_a_q [N_CH];
    logic [CNT_W-1:0] hp_a_d [N_CH];
    logic [CNT_W-1:0] hp_s_q [N_CH];
    logic [CNT_W-1:0] hp_s_d [N_CH];
    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  wr_hit;

    // Selects at or beyond N_CH match no channel, so such writes fall away.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = div_wr && (div_sel == SEL_W'(i));
        end
    end

    always_comb begin
        clk_out_d = clk_out_q;
        tick_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            hp_s_d[i] = wr_hit[i] ? div_val : hp_s_q[i];
            cnt_d[i]  = cnt_q[i];
            hp_a_d[i] = hp_a_q[i];
            if (!en[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                hp_a_d[i]    = hp_s_d[i];
            end
`ifdef CLKDIV_SYNC_EN
            else if (sync_req) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                hp_a_d[i]    = hp_s_d[i];
            end
`endif
            // >= rather than == so a counter beyond the active half-period still terminates.
            else if (cnt_q[i] >= hp_a_q[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = ~clk_out_q[i];
                tick_d[i]    = 1'b1;
                hp_a_d[i]    = hp_s_d[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out_q <= '0;
            tick_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                hp_a_q[i] <= DEF_HP[i*CNT_W +: CNT_W];
                hp_s_q[i] <= DEF_HP[i*CNT_W +: CNT_W];
            end
        end else begin
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hp_a_q[i] <= hp_a_d[i];
                hp_s_q[i] <= hp_s_d[i];
            end
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider_bank.sv
// tb/tb_clk_divider_bank.sv - scoreboard bench for clk_divider_bank against a schedule-based reference
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares after every posedge.
module tb_clk_divider_bank;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] en = '0;
    logic       div_wr = 1'b0;
    logic [2:0] div_sel = '0;
    logic [7:0] div_val = '0;
    logic       sync_req = 1'b0;
    logic [2:0] clk_out;
    logic [2:0] tick;

    clk_divider_bank dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_val (div_val),
`ifdef CLKDIV_SYNC_EN
        .sync_req(sync_req),
`endif
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    // Reference: each half-period is a window starting at edge seg_start and lasting hp+1 edges.
    int k = 0;
    int seg_start [N];
    int hp_act [N];
    int hp_sh [N];
    bit lvl [N];
    bit tk [N];
    int def_hp [N] = '{0, 5, 50};

    task automatic model_edge(input bit r, input logic [2:0] e, input bit w,
                              input int sel, input int val, input bit s);
        for (int c = 0; c < N; c++) begin
            tk[c] = 1'b0;
            if (r) begin
                hp_sh[c] = def_hp[c];
                hp_act[c] = def_hp[c];
                lvl[c] = 1'b0;
                seg_start[c] = k + 1;
            end else begin
                if (w && sel == c) hp_sh[c] = val;
                if (!e[c] || s) begin
                    lvl[c] = 1'b0;
                    hp_act[c] = hp_sh[c];
                    seg_start[c] = k + 1;
                end else if (k - seg_start[c] >= hp_act[c]) begin
                    lvl[c] = ~lvl[c];
                    tk[c] = 1'b1;
                    hp_act[c] = hp_sh[c];
                    seg_start[c] = k + 1;
                end
            end
        end
        k++;
    endtask

    task automatic step(input bit r, input logic [2:0] e, input bit w,
                        input int sel, input int val, input bit s);
        logic [5:0] ex;
        @(negedge clk);
        rst = r;
        en = e;
        div_wr = w;
        div_sel = 3'(sel);
        div_val = 8'(val);
`ifdef CLKDIV_SYNC_EN
        sync_req = s;
        model_edge(r, e, w, sel, val, s);
`else
        sync_req = s;
        model_edge(r, e, w, sel, val, 1'b0);
`endif
        for (int c = 0; c < N; c++) begin
            ex[c] = lvl[c];
            ex[c+3] = tk[c];
        end
        exp_q.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0, 1'b0);
    endtask

    // Advance until the reference predicts a toggle of channel c at the next edge.
    task automatic run_to_toggle(input int c);
        for (int i = 0; i < 600; i++) begin
            if (k - seg_start[c] >= hp_act[c]) return;
            idle(1);
        end
        checks++;
        errors++;
        $display("FAIL run_to_toggle ch%0d: toggle not reached, got none required one within 600 cycles", c);
    endtask

    initial begin : monitor
        logic [5:0] ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                checks++;
                if ({tick, clk_out} !== ex) begin
                    errors++;
                    if (errors <= 30)
                        $display("FAIL outputs edge: got tick=%b clk_out=%b required tick=%b clk_out=%b at %0t",
                                 tick, clk_out, ex[5:3], ex[2:0], $time);
                end
            end
        end
    end

    initial begin : stim
        // 1: reset, then free-run default half-periods 0/5/50
        step(1'b1, 3'b000, 1'b0, 0, 0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 0, 0, 1'b0);
        step(1'b0, 3'b111, 1'b0, 0, 0, 1'b0);
        idle(220);
        // 2: shorten ch1 mid-half
        run_to_toggle(1);
        idle(4);
        step(1'b0, en, 1'b1, 1, 2, 1'b0);
        idle(30);
        // 3: write in the exact toggle cycle takes the bypass path
        run_to_toggle(1);
        step(1'b0, en, 1'b1, 1, 9, 1'b0);
        idle(45);
        // 4: abort ch2 mid-period, reprogram while disabled, re-enable
        idle(7);
        step(1'b0, 3'b011, 1'b0, 0, 0, 1'b0);
        step(1'b0, 3'b011, 1'b1, 2, 1, 1'b0);
        idle(3);
        step(1'b0, 3'b111, 1'b0, 0, 0, 1'b0);
        idle(20);
        // 5: out-of-range selects
        step(1'b0, en, 1'b1, 3, 7, 1'b0);
        step(1'b0, en, 1'b1, 4, 7, 1'b0);
        idle(40);
        // 6: misalign ch1/ch2 then phase-align
        step(1'b0, en, 1'b1, 1, 5, 1'b0);
        idle(3);
        step(1'b0, en, 1'b1, 2, 11, 1'b0);
        idle(17);
        step(1'b0, en, 1'b0, 0, 0, 1'b1);
        idle(100);
        // Largest half-period on ch2
        step(1'b0, en, 1'b1, 2, 255, 1'b0);
        idle(560);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] e;
            bit w, r, s;
            int sel, val;
            e = en;
            if ($urandom_range(0, 31) == 0) e[$urandom_range(0, 2)] ^= 1'b1;
            w = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 4);
            val = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 63) == 0);
            step(r, e, w, sel, val, s);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
